ps2_wsad_decoder: RTL and testbench

PS2_WSAD_DECODER -- requirements
Module: ps2_wsad_decoder

---
 rtl/ps2_wsad_decoder.sv | 153 +++++++++++++++
 tb/tb_ps2_wsad_decoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_wsad_decoder.sv
// PS/2 keyboard receiver: frames bytes off the raw PS/2 lines and tracks held
// W/A/S/D and arrow keys as level outputs, plus per-scancode event reporting.
module ps2_wsad_decoder #(
    parameter int TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] wsad_down,
    output logic [3:0] arrow_down,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       frame_err
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_clk_s1, r_clk_s2, r_clk_prev;
    logic            r_dat_s1, r_dat_s2;
    logic            w_fall;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_parity;
    logic [TW-1:0]   r_to_cnt;
    logic            r_ext_pend, r_brk_pend;
    logic            w_timeout, w_start_err, w_frame_end;
    logic            w_frame_good, w_frame_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    // A falling edge restarts the inter-edge count, so it outranks the timeout.
    assign w_timeout = (r_state != IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_err = 1'b0;
        w_frame_end = 1'b0;
        if (w_timeout) begin
            w_state_nxt = IDLE;
        end else if (w_fall) begin
            case (r_state)
                IDLE: begin
                    if (!r_dat_s2) w_state_nxt = DATA;
                    else           w_start_err = 1'b1;
                end
                DATA:    if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
                PARITY:  w_state_nxt = STOP;
                STOP: begin
                    w_state_nxt = IDLE;
                    w_frame_end = 1'b1;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_frame_good = w_frame_end && r_dat_s2 && (^{r_shift, r_parity});
    assign w_frame_bad  = w_frame_end && !w_frame_good;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_to_cnt   <= '0;
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
            wsad_down  <= '0;
            arrow_down <= '0;
            key_valid  <= 1'b0;
            key_code   <= '0;
            key_ext    <= 1'b0;
            key_break  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= w_start_err | w_timeout | w_frame_bad;

            if (r_state == IDLE || w_fall || w_timeout) r_to_cnt <= '0;
            else                                        r_to_cnt <= r_to_cnt + TW'(1);

            if (w_fall) begin
                case (r_state)
                    IDLE:   r_bit_cnt <= '0;
                    DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    PARITY: r_parity <= r_dat_s2;
                    default: ;
                endcase
            end

            if (w_frame_bad) begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end else if (w_frame_good) begin
                if (r_shift == 8'hE0) begin
                    r_ext_pend <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_brk_pend <= 1'b1;
                end else begin
                    key_valid  <= 1'b1;
                    key_code   <= r_shift;
                    key_ext    <= r_ext_pend;
                    key_break  <= r_brk_pend;
                    r_ext_pend <= 1'b0;
                    r_brk_pend <= 1'b0;
                    case ({r_ext_pend, r_shift})
                        9'h01D: wsad_down[0]  <= !r_brk_pend;
                        9'h01C: wsad_down[1]  <= !r_brk_pend;
                        9'h01B: wsad_down[2]  <= !r_brk_pend;
                        9'h023: wsad_down[3]  <= !r_brk_pend;
                        9'h175: arrow_down[0] <= !r_brk_pend;
                        9'h16B: arrow_down[1] <= !r_brk_pend;
                        9'h172: arrow_down[2] <= !r_brk_pend;
                        9'h174: arrow_down[3] <= !r_brk_pend;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_wsad_decoder.sv
// Bench for ps2_wsad_decoder: scripted scancode table, corner-case sequences
// (timeout, start error, mid-frame reset) and random frames against a key model.
module tb_ps2_wsad_decoder;

    localparam int TO = 200;
    localparam int HP = 8;

    logic       clk = 1'b0;
    logic       rst, ps2_clk, ps2_data;
    logic [3:0] wsad_down, arrow_down;
    logic       key_valid, key_ext, key_break, frame_err;
    logic [7:0] key_code;

    always #5 clk = ~clk;

    ps2_wsad_decoder #(.TIMEOUT(TO)) u_dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .wsad_down(wsad_down), .arrow_down(arrow_down),
        .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
        .key_break(key_break), .frame_err(frame_err)
    );

    int total = 0;
    int bad   = 0;
    int kv_cnt = 0;
    int fe_cnt = 0;

    always @(negedge clk) begin
        if (key_valid) kv_cnt++;
        if (frame_err) fe_cnt++;
        if (key_valid || frame_err) begin
            total++;
            if (key_valid && frame_err) begin
                bad++;
                $display("FAIL excl: key_valid=%0b frame_err=%0b both high at %0t", key_valid, frame_err, $time);
            end
        end
    end

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HP) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HP) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] b, input bit flip, input int n);
        logic [10:0] f;
        f = {1'b1, (~(^b)) ^ flip, b, 1'b0};
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
    endtask

    task automatic settle();
        repeat (4 * HP) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip);
        send_bits(b, flip, 11);
        settle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wsad"},  32'(wsad_down),  32'h0);
        chk({tag, "_arrow"}, 32'(arrow_down), 32'h0);
        chk({tag, "_kv"},    32'(key_valid),  32'h0);
        chk({tag, "_code"},  32'(key_code),   32'h0);
        chk({tag, "_ext"},   32'(key_ext),    32'h0);
        chk({tag, "_brk"},   32'(key_break),  32'h0);
        chk({tag, "_fe"},    32'(frame_err),  32'h0);
    endtask

    typedef struct {
        logic [7:0] code;
        bit         flip;
        logic [3:0] wsad;
        logic [3:0] arrow;
        int         dkv;
        int         dfe;
        logic [7:0] kcode;
        bit         ext;
        bit         brk;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [7:0] c, input bit fl, input logic [3:0] w, input logic [3:0] a,
                       input int dk, input int df, input logic [7:0] kc, input bit e, input bit b);
        vec_t v;
        v.code = c; v.flip = fl; v.wsad = w; v.arrow = a; v.dkv = dk; v.dfe = df;
        v.kcode = kc; v.ext = e; v.brk = b;
        vecs.push_back(v);
    endtask

    // Reference model: held keys indexed by slot, slots 4..7 need the E0 prefix.
    logic [7:0] keymap [8] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h72, 8'h74};
    bit         held [8];
    bit         m_extp, m_brkp, m_ext, m_brk;
    logic [7:0] m_code;

    function automatic logic [3:0] held_nib(input int base);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = held[base + i];
        return r;
    endfunction

    initial begin
        int kv0, fe0, exp_kv, exp_fe;
        logic [7:0] c;
        bit fl;

        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_reset_vals("por");

        add(8'h1D, 0, 4'b0001, 4'b0000, 1, 0, 8'h1D, 0, 0);
        add(8'hF0, 0, 4'b0001, 4'b0000, 0, 0, 8'h1D, 0, 0);
        add(8'h1D, 0, 4'b0000, 4'b0000, 1, 0, 8'h1D, 0, 1);
        add(8'hE0, 0, 4'b0000, 4'b0000, 0, 0, 8'h1D, 0, 1);
        add(8'h6B, 0, 4'b0000, 4'b0010, 1, 0, 8'h6B, 1, 0);
        add(8'h1C, 0, 4'b0010, 4'b0010, 1, 0, 8'h1C, 0, 0);
        add(8'h23, 1, 4'b0010, 4'b0010, 0, 1, 8'h1C, 0, 0);
        add(8'h23, 0, 4'b1010, 4'b0010, 1, 0, 8'h23, 0, 0);
        add(8'hE0, 0, 4'b1010, 4'b0010, 0, 0, 8'h23, 0, 0);
        add(8'h11, 1, 4'b1010, 4'b0010, 0, 1, 8'h23, 0, 0);
        add(8'h75, 0, 4'b1010, 4'b0010, 1, 0, 8'h75, 0, 0);
        add(8'hE0, 0, 4'b1010, 4'b0010, 0, 0, 8'h75, 0, 0);
        add(8'h1D, 0, 4'b1010, 4'b0010, 1, 0, 8'h1D, 1, 0);
        add(8'h1C, 0, 4'b1010, 4'b0010, 1, 0, 8'h1C, 0, 0);
        add(8'hE0, 0, 4'b1010, 4'b0010, 0, 0, 8'h1C, 0, 0);
        add(8'hF0, 0, 4'b1010, 4'b0010, 0, 0, 8'h1C, 0, 0);
        add(8'h6B, 0, 4'b1010, 4'b0000, 1, 0, 8'h6B, 1, 1);
        add(8'hE0, 0, 4'b1010, 4'b0000, 0, 0, 8'h6B, 1, 1);
        add(8'h72, 0, 4'b1010, 4'b0100, 1, 0, 8'h72, 1, 0);
        add(8'hF0, 0, 4'b1010, 4'b0100, 0, 0, 8'h72, 1, 0);
        add(8'h1C, 0, 4'b1000, 4'b0100, 1, 0, 8'h1C, 0, 1);

        foreach (vecs[i]) begin
            kv0 = kv_cnt; fe0 = fe_cnt;
            send_frame(vecs[i].code, vecs[i].flip);
            chk($sformatf("v%0d_wsad", i),  32'(wsad_down),   32'(vecs[i].wsad));
            chk($sformatf("v%0d_arrow", i), 32'(arrow_down),  32'(vecs[i].arrow));
            chk($sformatf("v%0d_kv", i),    32'(kv_cnt - kv0), 32'(vecs[i].dkv));
            chk($sformatf("v%0d_fe", i),    32'(fe_cnt - fe0), 32'(vecs[i].dfe));
            chk($sformatf("v%0d_code", i),  32'(key_code),    32'(vecs[i].kcode));
            chk($sformatf("v%0d_ext", i),   32'(key_ext),     32'(vecs[i].ext));
            chk($sformatf("v%0d_brk", i),   32'(key_break),   32'(vecs[i].brk));
        end

        // Timeout: abandon a frame after 4 data bits.
        kv0 = kv_cnt; fe0 = fe_cnt;
        send_bits(8'h1B, 0, 5);
        repeat (TO - 30) @(negedge clk);
        @(posedge clk); #1;
        chk("to_early_fe", 32'(fe_cnt - fe0), 32'd0);
        repeat (40) @(negedge clk);
        @(posedge clk); #1;
        chk("to_fe", 32'(fe_cnt - fe0), 32'd1);
        chk("to_kv", 32'(kv_cnt - kv0), 32'd0);
        chk("to_wsad", 32'(wsad_down), 32'b1000);
        kv0 = kv_cnt; fe0 = fe_cnt;
        send_frame(8'h1B, 0);
        chk("to_next_wsad", 32'(wsad_down), 32'b1100);
        chk("to_next_kv", 32'(kv_cnt - kv0), 32'd1);
        chk("to_next_fe", 32'(fe_cnt - fe0), 32'd0);

        // Start bit of 1 is rejected, decoding recovers afterwards.
        fe0 = fe_cnt; kv0 = kv_cnt;
        ps2_bit(1'b1);
        settle();
        chk("start_fe", 32'(fe_cnt - fe0), 32'd1);
        chk("start_kv", 32'(kv_cnt - kv0), 32'd0);
        fe0 = fe_cnt;
        send_frame(8'h1B, 0);
        chk("start_next_wsad", 32'(wsad_down), 32'b1100);
        chk("start_next_fe", 32'(fe_cnt - fe0), 32'd0);

        // Reset in the middle of a frame.
        do_reset();
        send_frame(8'h1D, 0);
        send_frame(8'h23, 0);
        chk("mr_pre_wsad", 32'(wsad_down), 32'b1001);
        send_bits(8'h1C, 0, 5);
        do_reset();
        chk_reset_vals("mr");
        kv0 = kv_cnt; fe0 = fe_cnt;
        send_frame(8'h1C, 0);
        chk("mr_next_wsad", 32'(wsad_down), 32'b0010);
        chk("mr_next_kv", 32'(kv_cnt - kv0), 32'd1);
        chk("mr_next_fe", 32'(fe_cnt - fe0), 32'd0);

        // Random frames against the model.
        do_reset();
        foreach (held[i]) held[i] = 1'b0;
        m_extp = 0; m_brkp = 0; m_ext = 0; m_brk = 0; m_code = 8'h00;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0:       c = 8'hE0;
                1:       c = 8'hF0;
                2:       c = 8'($urandom_range(0, 255));
                default: c = keymap[$urandom_range(0, 7)];
            endcase
            fl = ($urandom_range(0, 9) == 0);
            exp_kv = 0; exp_fe = 0;
            if (fl) begin
                exp_fe = 1; m_extp = 0; m_brkp = 0;
            end else if (c == 8'hE0) begin
                m_extp = 1;
            end else if (c == 8'hF0) begin
                m_brkp = 1;
            end else begin
                exp_kv = 1;
                for (int k = 0; k < 8; k++)
                    if (keymap[k] == c && ((k >= 4) == m_extp)) held[k] = !m_brkp;
                m_code = c; m_ext = m_extp; m_brk = m_brkp;
                m_extp = 0; m_brkp = 0;
            end
            kv0 = kv_cnt; fe0 = fe_cnt;
            send_frame(c, fl);
            chk($sformatf("r%0d_wsad", n),  32'(wsad_down),    32'(held_nib(0)));
            chk($sformatf("r%0d_arrow", n), 32'(arrow_down),   32'(held_nib(4)));
            chk($sformatf("r%0d_kv", n),    32'(kv_cnt - kv0), 32'(exp_kv));
            chk($sformatf("r%0d_fe", n),    32'(fe_cnt - fe0), 32'(exp_fe));
            chk($sformatf("r%0d_code", n),  32'(key_code),     32'(m_code));
            chk($sformatf("r%0d_flags", n), 32'({key_ext, key_break}), 32'({m_ext, m_brk}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
